// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module   : control_sequencer_if
// Brief    : Control bundle between the microcode sequencer and the datapath:
//            opcode/flag inputs and every register ie/oe/step strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if #(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
);
  // decode inputs
  logic [OPCODE_W-1:0] opcode;
  logic                carry;
  logic                zero;
  // datapath strobes
  logic                pc_oe;
  logic                pc_ie;
  logic                pc_step;
  logic                mar_ie;
  logic                ram_oe;
  logic                ram_ie;
  logic                ir_ie;
  logic                ir_oe;
  logic                a_ie;
  logic                a_oe;
  logic                b_ie;
  logic                alu_oe;
  logic                alu_sub;
  logic                flags_ie;
  logic                out_ie;
  logic                halt;
  logic [STEP_W-1:0]   t_state;

  // sequencer side
  modport master (
    input  opcode, carry, zero,
    output pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, halt, t_state
  );

  // datapath side
  modport slave (
    output opcode, carry, zero,
    input  pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, halt, t_state
  );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Microcode sequencer for the 8-bit shared-bus CPU. Steps T0..T4,
//            decodes opcode and flags, drives at most one bus driver per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  control_sequencer_if.master    bus
);

  typedef enum logic [STEP_W-1:0] {
    T0 = STEP_W'(0),
    T1 = STEP_W'(1),
    T2 = STEP_W'(2),
    T3 = STEP_W'(3),
    T4 = STEP_W'(4)
  } step_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  step_t state;
  step_t state_next;
  logic  halted;
  logic  halted_next;

  assign bus.t_state = state;

  // T-state counter and sticky halt bit; rst restarts at the T0 fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // Microcode decode: strobes for the current step and the step that follows
  always_comb begin
    state_next   = state;
    halted_next  = halted;
    bus.pc_oe    = 1'b0;
    bus.pc_ie    = 1'b0;
    bus.pc_step  = 1'b0;
    bus.mar_ie   = 1'b0;
    bus.ram_oe   = 1'b0;
    bus.ram_ie   = 1'b0;
    bus.ir_ie    = 1'b0;
    bus.ir_oe    = 1'b0;
    bus.a_ie     = 1'b0;
    bus.a_oe     = 1'b0;
    bus.b_ie     = 1'b0;
    bus.alu_oe   = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.flags_ie = 1'b0;
    bus.out_ie   = 1'b0;
    bus.halt     = 1'b0;

    // Nothing is driven during the reset cycle, so a half-run instruction
    // cannot leak a partial write into the datapath.
    if (!rst) begin
      if (halted) begin
        bus.halt = 1'b1;
      end else begin
        case (state)
          T0: begin
            bus.pc_oe  = 1'b1;
            bus.mar_ie = 1'b1;
            state_next = T1;
          end
          T1: begin
            bus.ram_oe  = 1'b1;
            bus.ir_ie   = 1'b1;
            bus.pc_step = 1'b1;
            state_next  = T2;
          end
          T2: begin
            state_next = T0;
            case (bus.opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                bus.ir_oe  = 1'b1;
                bus.mar_ie = 1'b1;
                state_next = T3;
              end
              OP_LDI: begin
                bus.ir_oe = 1'b1;
                bus.a_ie  = 1'b1;
              end
              OP_JMP: begin
                bus.ir_oe = 1'b1;
                bus.pc_ie = 1'b1;
              end
              OP_JC: begin
                bus.ir_oe = bus.carry;
                bus.pc_ie = bus.carry;
              end
              OP_JZ: begin
                bus.ir_oe = bus.zero;
                bus.pc_ie = bus.zero;
              end
              OP_OUT: begin
                bus.a_oe   = 1'b1;
                bus.out_ie = 1'b1;
              end
              OP_HLT: begin
                bus.halt    = 1'b1;
                halted_next = 1'b1;
                state_next  = T2;
              end
              default: ;  // NOP and undefined opcodes
            endcase
          end
          T3: begin
            state_next = T0;
            case (bus.opcode)
              OP_LDA: begin
                bus.ram_oe = 1'b1;
                bus.a_ie   = 1'b1;
              end
              OP_ADD, OP_SUB: begin
                bus.ram_oe = 1'b1;
                bus.b_ie   = 1'b1;
                state_next = T4;
              end
              OP_STA: begin
                bus.a_oe   = 1'b1;
                bus.ram_ie = 1'b1;
              end
              default: ;
            endcase
          end
          T4: begin
            bus.alu_oe   = 1'b1;
            bus.a_ie     = 1'b1;
            bus.flags_ie = 1'b1;
            bus.alu_sub  = (bus.opcode == OP_SUB);
            state_next   = T0;
          end
          default: state_next = T0;  // recover from any unused count
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Self-checking bench for control_sequencer; a table-driven
//            microcode model predicts every strobe and T-state per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_control_sequencer;

  // strobe vector bit positions
  localparam int PC_OE = 0, PC_IE = 1, PC_STEP = 2, MAR_IE = 3, RAM_OE = 4,
                 RAM_IE = 5, IR_IE = 6, IR_OE = 7, A_IE = 8, A_OE = 9,
                 B_IE = 10, ALU_OE = 11, ALU_SUB = 12, FLAGS_IE = 13,
                 OUT_IE = 14, HALT = 15;
  localparam logic [15:0] DRV_MASK = (16'd1 << PC_OE) | (16'd1 << RAM_OE) |
                                     (16'd1 << IR_OE) | (16'd1 << A_OE) |
                                     (16'd1 << ALU_OE);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] obs;
  assign obs = {bus.halt, bus.out_ie, bus.flags_ie, bus.alu_sub, bus.alu_oe,
                bus.b_ie, bus.a_oe, bus.a_ie, bus.ir_oe, bus.ir_ie,
                bus.ram_ie, bus.ram_oe, bus.mar_ie, bus.pc_step,
                bus.pc_ie, bus.pc_oe};

  // reference model: microcode table + instruction lengths
  logic [15:0] uc [16][5];
  int          len [16];
  int          m_k;
  bit          m_halted;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] bits2(int a, int b);
    return (16'd1 << a) | (16'd1 << b);
  endfunction

  function automatic logic [15:0] bits3(int a, int b, int c);
    return (16'd1 << a) | (16'd1 << b) | (16'd1 << c);
  endfunction

  function automatic logic [15:0] model_out();
    logic [15:0] v;
    if (rst) return 16'h0;
    if (m_halted) return 16'd1 << HALT;
    v = uc[bus.opcode][m_k];
    if (m_k == 2 && bus.opcode == 4'h7 && !bus.carry) v = 16'h0;
    if (m_k == 2 && bus.opcode == 4'h8 && !bus.zero)  v = 16'h0;
    return v;
  endfunction

  task automatic advance();
    if (rst) begin
      m_k = 0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_k = 2;
    end else if (bus.opcode == 4'hF && m_k == 2) begin
      m_halted = 1'b1;
    end else begin
      m_k = (m_k + 1 >= len[bus.opcode]) ? 0 : m_k + 1;
    end
  endtask

  // check current cycle against the model, then take one clock edge
  task automatic cycle();
    logic [15:0] e;
    #1;
    e = model_out();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL strobes op=%0h k=%0d rst=%0b: got %h want %h",
             bus.opcode, m_k, rst, obs, e);
    end
    if (!rst) begin
      checks++;
      assert (bus.t_state === 3'(m_k)) else begin
        errors++;
        $error("FAIL t_state op=%0h: got %0d want %0d", bus.opcode, bus.t_state, m_k);
      end
    end
    checks++;
    assert ($countones(obs & DRV_MASK) <= 1) else begin
      errors++;
      $error("FAIL bus_drivers: got %h want at most one of %h", obs & DRV_MASK, DRV_MASK);
    end
    @(posedge clk);
    advance();
    #1;
  endtask

  // run one full instruction from T0 back to T0 (bounded)
  task automatic run_instr(logic [3:0] op, logic c, logic z);
    int n = 0;
    bus.opcode = op;
    bus.carry  = c;
    bus.zero   = z;
    do begin
      cycle();
      n++;
    end while (m_k != 0 && n < 8);
    checks++;
    assert (n == len[op]) else begin
      errors++;
      $error("FAIL period op=%0h: got %0d want %0d", op, n, len[op]);
    end
  endtask

  initial begin
    // build microcode table from the instruction set description
    for (int o = 0; o < 16; o++) begin
      for (int k = 0; k < 5; k++) uc[o][k] = 16'h0;
      uc[o][0] = bits2(PC_OE, MAR_IE);
      uc[o][1] = bits3(RAM_OE, IR_IE, PC_STEP);
      len[o]   = 3;
    end
    uc[1][2] = bits2(IR_OE, MAR_IE); uc[1][3] = bits2(RAM_OE, A_IE); len[1] = 4;
    for (int o = 2; o <= 3; o++) begin
      uc[o][2] = bits2(IR_OE, MAR_IE);
      uc[o][3] = bits2(RAM_OE, B_IE);
      uc[o][4] = bits3(ALU_OE, A_IE, FLAGS_IE);
      len[o]   = 5;
    end
    uc[3][4] = uc[3][4] | (16'd1 << ALU_SUB);
    uc[4][2] = bits2(IR_OE, MAR_IE); uc[4][3] = bits2(A_OE, RAM_IE); len[4] = 4;
    uc[5][2] = bits2(IR_OE, A_IE);
    uc[6][2] = bits2(IR_OE, PC_IE);
    uc[7][2] = bits2(IR_OE, PC_IE);
    uc[8][2] = bits2(IR_OE, PC_IE);
    uc[14][2] = bits2(A_OE, OUT_IE);
    uc[15][2] = 16'd1 << HALT;
    m_k = 0;
    m_halted = 1'b0;

    // reset for two cycles
    bus.opcode = 4'h0;
    bus.carry  = 1'b0;
    bus.zero   = 1'b0;
    rst = 1'b1;
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    assert (bus.pc_oe === 1'b1 && bus.mar_ie === 1'b1 && bus.t_state === 3'd0) else begin
      errors++;
      $error("FAIL reset_release: got pc_oe=%b mar_ie=%b t=%0d want 1 1 0",
             bus.pc_oe, bus.mar_ie, bus.t_state);
    end

    // fetch + each instruction class
    run_instr(4'h1, 1'b0, 1'b0);  // LDA
    run_instr(4'h3, 1'b0, 1'b0);  // SUB
    run_instr(4'h2, 1'b1, 1'b1);  // ADD
    run_instr(4'h4, 1'b0, 1'b0);  // STA
    run_instr(4'h5, 1'b0, 1'b0);  // LDI
    run_instr(4'h6, 1'b0, 1'b0);  // JMP
    run_instr(4'h7, 1'b0, 1'b1);  // JC not taken
    run_instr(4'h7, 1'b1, 1'b0);  // JC taken
    run_instr(4'h8, 1'b1, 1'b0);  // JZ not taken
    run_instr(4'h8, 1'b0, 1'b1);  // JZ taken
    run_instr(4'hE, 1'b0, 1'b0);  // OUT
    run_instr(4'hB, 1'b1, 1'b1);  // undefined -> NOP
    run_instr(4'h0, 1'b0, 1'b0);  // NOP

    // halt: sticky until reset
    bus.opcode = 4'hF;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    assert (bus.halt === 1'b1 && bus.t_state === 3'd2) else begin
      errors++;
      $error("FAIL halt_sticky: got halt=%b t=%0d want 1 2", bus.halt, bus.t_state);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    assert (bus.halt === 1'b0 && bus.t_state === 3'd0) else begin
      errors++;
      $error("FAIL halt_clear: got halt=%b t=%0d want 0 0", bus.halt, bus.t_state);
    end

    // reset in T3 of ADD: b_ie must never fire
    bus.opcode = 4'h2;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    #1;
    checks++;
    assert (bus.b_ie === 1'b0 && bus.t_state === 3'd3) else begin
      errors++;
      $error("FAIL rst_in_t3: got b_ie=%b t=%0d want 0 3", bus.b_ie, bus.t_state);
    end
    cycle();
    rst = 1'b0;
    run_instr(4'h2, 1'b0, 1'b0);

    // random opcode/flag/reset stream
    for (int i = 0; i < 10000; i++) begin
      if (m_k == 0)
        bus.opcode = ($urandom_range(0, 49) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      bus.carry = 1'($urandom);
      bus.zero  = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
